serial_tx_fifo: RTL and testbench
=================================

Name: serial_tx_fifo

Overview:
Buffered 8N1 UART transmitter that returns data from the FPGA to the host PC. Logic writes bytes into an internal FIFO without waiting on the line. The block drains the FIFO onto `tx` one frame at a time and honours the host flow-control input `block`. It is the transmit-direction counterpart to the receive path in the host serial link, and is used where bursty responses must not stall the producer.

Parameters:
- CLK_PER_BIT, 100: clock cycles per serial bit (50 MHz / 500 kbaud); minimum 2.
- DEPTH_LOG2, 4: log2 of FIFO depth (default depth 16 bytes).

Ports:
- clk, input, 1: system clock; all logic rises on the posedge.
- rst, input, 1: asynchronous active-low reset.
- wr_en, input, 1: write strobe; `wr_data` is captured on a clk edge when high and not full.
- wr_data, input, 8: byte to queue.
- block, input, 1: host flow control; while high, no new frame is started.
- tx, output, 1: serial line, idle high.
- busy, output, 1: high while a frame is on the line or the FIFO is non-empty.
- full, output, 1: FIFO holds DEPTH bytes.
- empty, output, 1: FIFO holds 0 bytes.
- count, output, DEPTH_LOG2+1: current FIFO occupancy, 0..DEPTH.
- overflow, output, 1: one-cycle pulse when `wr_en` is high while full; the byte is dropped.

Behaviour:
- Reset (rst low, asynchronous): tx=1, busy=0, full=0, empty=1, count=0, overflow=0, FSM=IDLE. Read/write pointers, bit counter and clock counter cleared. Reset mid-frame aborts the frame; tx goes high immediately and queued bytes are lost.
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit pointers that wrap naturally from DEPTH-1 to 0.
  - count, full and empty are registered and reflect state after the edge.
  - Write when full: ignored, count unchanged, overflow=1 for that cycle.
  - Simultaneous write and pop: count unchanged, both pointers advance. This is legal when full because the pop frees a slot in the same edge.
  - Pop happens only from registered non-empty state. A write into an empty FIFO cannot be popped in the same cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If !empty && !block, pop the head byte into the shift register, clear the clock counter, and go to START.
  - START: tx=0 for CLK_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLK_PER_BIT cycles; shift right after each bit. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for CLK_PER_BIT cycles, then go to IDLE.
- tx is registered.
- Latency: with the FSM idle, block low and the FIFO empty, `wr_en` sampled at edge N gives empty=0 after N. The pop occurs at edge N+1. tx falls after edge N+2.
- Back-to-back frames: there is always exactly one IDLE cycle between the end of STOP and the next START. Frame period is 10*CLK_PER_BIT+1 cycles.
- block:
  - Sampled only in IDLE.
  - Asserting it mid-frame does not truncate the frame; the current frame completes.
  - Release while the FIFO is non-empty: pop on the first IDLE edge with block low.
- busy = (FSM != IDLE) || !empty, registered-equivalent. It drops the cycle after the last stop bit ends and the FIFO is empty.
- Clock counter: counts 0..CLK_PER_BIT-1 and is cleared on every bit transition. No fractional baud correction.

Test Plan:
All scenarios use CLK_PER_BIT=4 and DEPTH_LOG2=2.
1. Reset release, then write 0xA5 once:
   - tx falls 2 cycles after the write edge.
   - Line reads 0,1,0,1,0,0,1,0,1,1, each level held for 4 cycles.
   - busy drops 1 cycle after the stop bit ends; count returns to 0.
2. Write 0x00,0xFF,0x55,0x3C on consecutive cycles:
   - full=1 after the 4th write (the first byte may already be popped; check count=3 or 4 per the latency rule).
   - All four frames appear in order, each 41 cycles apart.
3. Fill the FIFO to 4 with block high, then write 0x77:
   - overflow pulses for 1 cycle, count stays 4, tx stays 1.
   - Drop block: the four original bytes are transmitted and 0x77 never appears.
4. While full with block low, write on the exact cycle of a pop:
   - The byte is accepted, count stays 4, no overflow.
   - The new byte is sent last in order.
5. Raise block during the DATA bits of frame 1 with 2 bytes queued:
   - Frame 1 completes intact; tx stays high while block is high.
   - Dropping block starts the next frame 2 cycles later (1 IDLE sample edge, then START).
6. Pull rst low mid-DATA:
   - tx=1, busy=0, empty=1, count=0 asynchronously.
   - After release, the line stays idle until a new write.

Source files
------------

// File: rtl/serial_tx_fifo_if.sv
// Write-side bus of the buffered serial transmitter: producer strobe/data
// and the FIFO status flags returned to the producer.
interface serial_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
) ();
  logic                wr_en;
  logic [7:0]          wr_data;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;

  // Producer side: drives writes, observes occupancy.
  modport master (
    output wr_en, wr_data,
    input  full, empty, count, overflow
  );

  // Transmitter side: accepts writes, reports occupancy.
  modport slave (
    input  wr_en, wr_data,
    output full, empty, count, overflow
  );
endinterface

// File: rtl/serial_tx_fifo.sv
// Buffered 8N1 UART transmitter. Bytes are queued in a circular FIFO and
// drained onto tx one frame at a time, with host flow control via block.
module serial_tx_fifo #(
  parameter int CLK_PER_BIT = 100,
  parameter int DEPTH_LOG2  = 4
) (
  input  logic             clk,
  input  logic             rst,
  serial_tx_fifo_if.slave  wr,
  input  logic             block,
  output logic             tx,
  output logic             busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]      BIT_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  line;
  logic                  pop;
  logic                  accept;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, empty_q, overflow_q;
  logic                  tx_q, busy_q;
  logic                  bit_end;

  assign bit_end = (clk_cnt_q == BIT_LAST);

  // A write is taken when there is room, or when a pop frees a slot this edge.
  assign accept = wr.wr_en && (!full_q || pop);

  // Frame sequencing: next state, bit timing and the level for the line register.
  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    line      = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!empty_q && !block) begin
          pop       = 1'b1;
          shift_d   = mem[rd_ptr];
          clk_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        line = 1'b0;
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DATA: begin
        line = shift_q[0];
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      STOP: begin
        line = 1'b1;
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy after this edge: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FSM, shift register and line registers; tx lags the state by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state uses non-blocking assignment so all flops update together.
    if (!rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= line;
      busy_q    <= (state_q != IDLE) || !empty_q;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the array is not reset; pointers and count alone define valid data.
    if (accept) mem[wr_ptr] <= wr.wr_data;
  end

  // FIFO pointers and registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count_q    <= count_d;
      full_q     <= (count_d == FULL_CNT);
      empty_q    <= (count_d == '0);
      overflow_q <= wr.wr_en && full_q && !pop;
    end
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign wr.full     = full_q;
  assign wr.empty    = empty_q;
  assign wr.count    = count_q;
  assign wr.overflow = overflow_q;

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Self-checking bench for serial_tx_fifo: a queue-based frame model checked
// every cycle, an independent line decoder, and directed plus random stimulus.
module tb_serial_tx_fifo;

  localparam int CPB   = 4;
  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;
  localparam int FRAME = 10 * CPB;

  logic clk;
  logic rst;
  logic block;
  logic tx;
  logic busy;

  serial_tx_fifo_if #(.DEPTH_LOG2(DL2)) wr_bus ();

  serial_tx_fifo #(.CLK_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr_bus.slave),
    .block (block),
    .tx    (tx),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Behavioural model: queue of pending bytes plus position within the frame.
  logic [7:0] mq[$];
  logic [7:0] m_sent[$];
  bit         m_active;
  int         m_pos;
  logic [7:0] m_byte;
  logic       m_tx, m_busy, m_ovf;

  // Line decoder output.
  logic [7:0] rx_q[$];
  int         rx_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic level(input int pos, input logic [7:0] b);
    int bi;
    bi = pos / CPB;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    return b[bi-1];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_pos    = 0;
    m_byte   = '0;
    m_tx     = 1'b1;
    m_busy   = 1'b0;
    m_ovf    = 1'b0;
  endtask

  // Advance the model across one clock edge using the inputs present at that edge.
  task automatic model_advance();
    int  pre_size;
    bit  do_pop;
    logic tx_n, busy_n;
    if (!rst) return;
    pre_size = mq.size();
    do_pop   = !m_active && (pre_size != 0) && !block;
    tx_n     = m_active ? level(m_pos, m_byte) : 1'b1;
    busy_n   = m_active || (pre_size != 0);
    if (m_active) begin
      if (m_pos == FRAME - 1) m_active = 1'b0;
      else                    m_pos++;
    end else if (do_pop) begin
      m_active = 1'b1;
      m_pos    = 0;
      m_byte   = mq.pop_front();
      m_sent.push_back(m_byte);
    end
    m_ovf = 1'b0;
    if (wr_bus.wr_en) begin
      if (pre_size == DEPTH && !do_pop) m_ovf = 1'b1;
      else                              mq.push_back(wr_bus.wr_data);
    end
    m_tx   = tx_n;
    m_busy = busy_n;
  endtask

  task automatic step(input logic we, input logic [7:0] d, input logic blk);
    wr_bus.wr_en   = we;
    wr_bus.wr_data = d;
    block          = blk;
    @(posedge clk);
    model_advance();
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input logic blk);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, blk);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_cyc.delete();
    m_sent.delete();
  endtask

  // Compare process: every output against the model, away from the edge.
  initial forever begin
    @(negedge clk);
    check("cmp_tx",       tx,              m_tx);
    check("cmp_busy",     busy,            m_busy);
    check("cmp_overflow", wr_bus.overflow, m_ovf);
    check("cmp_count",    wr_bus.count,    mq.size());
    check("cmp_full",     wr_bus.full,     mq.size() == DEPTH);
    check("cmp_empty",    wr_bus.empty,    mq.size() == 0);
  end

  // Independent line decoder: samples mid-bit, records byte and start cycle.
  initial begin
    bit         d_on;
    int         d_cnt;
    int         d_start;
    logic [7:0] d_byte;
    d_on = 1'b0; d_cnt = 0; d_start = 0; d_byte = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        d_on = 1'b0;
      end else if (!d_on) begin
        if (tx === 1'b0) begin
          d_on = 1'b1; d_cnt = 0; d_start = cyc;
        end
      end else begin
        d_cnt++;
        if (d_cnt % CPB == CPB / 2 && d_cnt > CPB && d_cnt < 9 * CPB)
          d_byte[d_cnt / CPB - 1] = tx;
        if (d_cnt == 9 * CPB + CPB / 2) begin
          rx_q.push_back(d_byte);
          rx_cyc.push_back(d_start);
          d_on = 1'b0;
        end
      end
    end
  end

  initial begin
    int         exp_line[10];
    logic [7:0] s2[4];
    logic [7:0] s3[4];
    logic       blk;
    exp_line = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    s2 = '{8'h00, 8'hFF, 8'h55, 8'h3C};
    s3 = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst = 1'b0;
    wr_bus.wr_en = 1'b0; wr_bus.wr_data = '0; block = 1'b0;
    model_reset();
    idle(3, 1'b0);
    check("reset_tx",    tx,           1);
    check("reset_busy",  busy,         0);
    check("reset_empty", wr_bus.empty, 1);
    check("reset_count", wr_bus.count, 0);
    rst = 1'b1;
    idle(2, 1'b0);

    // Single byte 0xA5: exact line waveform and busy tail.
    clear_rx();
    step(1'b1, 8'hA5, 1'b0);
    check("s1_empty_after_write", wr_bus.empty, 0);
    step(1'b0, 8'h00, 1'b0);
    check("s1_tx_high_before_start", tx, 1);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < FRAME; i++) begin
      check("s1_line", tx, exp_line[i / CPB]);
      if (i == FRAME - 1) check("s1_busy_in_stop", busy, 1);
      step(1'b0, 8'h00, 1'b0);
    end
    check("s1_busy_dropped", busy, 0);
    check("s1_count_zero", wr_bus.count, 0);
    idle(3, 1'b0);
    check("s1_rx_count", rx_q.size(), 1);
    if (rx_q.size() >= 1) check("s1_rx_byte", rx_q[0], 8'hA5);

    // Four consecutive writes: first is already popped, frames 41 cycles apart.
    clear_rx();
    for (int i = 0; i < 4; i++) step(1'b1, s2[i], 1'b0);
    check("s2_count_after_burst", wr_bus.count, 3);
    check("s2_full_after_burst", wr_bus.full, 0);
    idle(4 * (FRAME + 1) + 10, 1'b0);
    check("s2_rx_count", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rx_q.size()) check("s2_rx_byte", rx_q[i], s2[i]);
      if (i + 1 < rx_cyc.size()) check("s2_frame_period", rx_cyc[i+1] - rx_cyc[i], FRAME + 1);
    end

    // Fill under block, overflow drops 0x77, then drain.
    clear_rx();
    for (int i = 0; i < 4; i++) step(1'b1, s3[i], 1'b1);
    check("s3_count_full", wr_bus.count, 4);
    check("s3_full", wr_bus.full, 1);
    step(1'b1, 8'h77, 1'b1);
    check("s3_overflow_pulse", wr_bus.overflow, 1);
    check("s3_count_held", wr_bus.count, 4);
    check("s3_tx_idle", tx, 1);
    step(1'b0, 8'h00, 1'b1);
    check("s3_overflow_cleared", wr_bus.overflow, 0);
    idle(5, 1'b1);
    check("s3_tx_blocked", tx, 1);
    idle(4 * (FRAME + 1) + 10, 1'b0);
    check("s3_rx_count", rx_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < rx_q.size()) check("s3_rx_byte", rx_q[i], s3[i]);

    // Write on the exact pop edge while full: accepted, sent last.
    clear_rx();
    for (int i = 0; i < 4; i++) step(1'b1, 8'h61 + 8'(i), 1'b1);
    step(1'b1, 8'h99, 1'b0);
    check("s4_count_held", wr_bus.count, 4);
    check("s4_no_overflow", wr_bus.overflow, 0);
    check("s4_full", wr_bus.full, 1);
    idle(5 * (FRAME + 1) + 10, 1'b0);
    check("s4_rx_count", rx_q.size(), 5);
    for (int i = 0; i < 4; i++)
      if (i < rx_q.size()) check("s4_rx_byte", rx_q[i], 8'h61 + 8'(i));
    if (rx_q.size() >= 5) check("s4_rx_last", rx_q[4], 8'h99);

    // Block raised mid-frame: frame completes, next start waits for release.
    clear_rx();
    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    idle(10, 1'b0);
    idle(FRAME + 5, 1'b1);
    check("s5_count_waiting", wr_bus.count, 2);
    check("s5_tx_held", tx, 1);
    check("s5_frame1_count", rx_q.size(), 1);
    if (rx_q.size() >= 1) check("s5_frame1_byte", rx_q[0], 8'hC1);
    step(1'b0, 8'h00, 1'b0);
    check("s5_tx_after_release_edge", tx, 1);
    step(1'b0, 8'h00, 1'b0);
    check("s5_start_bit", tx, 0);
    idle(2 * (FRAME + 1) + 10, 1'b0);
    check("s5_rx_count", rx_q.size(), 3);
    if (rx_q.size() >= 3) begin
      check("s5_rx_byte2", rx_q[1], 8'hC2);
      check("s5_rx_byte3", rx_q[2], 8'hC3);
    end

    // Asynchronous reset mid-DATA.
    clear_rx();
    step(1'b1, 8'hE7, 1'b0);
    idle(15, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("s6_tx_async", tx, 1);
    check("s6_busy_async", busy, 0);
    check("s6_empty_async", wr_bus.empty, 1);
    check("s6_count_async", wr_bus.count, 0);
    idle(2, 1'b0);
    rst = 1'b1;
    idle(60, 1'b0);
    check("s6_line_quiet", rx_q.size(), 0);
    check("s6_tx_idle", tx, 1);

    // Random traffic with bursty writes and toggling flow control.
    clear_rx();
    blk = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) blk = ~blk;
      step($urandom_range(0, 99) < 35, 8'($urandom), blk);
    end
    idle(6 * (FRAME + 1), 1'b0);
    check("rand_drained", wr_bus.empty, 1);
    check("rand_rx_count", rx_q.size(), m_sent.size());
    for (int i = 0; i < m_sent.size(); i++)
      if (i < rx_q.size()) check("rand_rx_byte", rx_q[i], m_sent[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
